// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Control/handshake bundle between the multi-cycle FSM and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
           dmem_req, dmem_we, reg_write, wb_sel, halted, illegal, bus_err, instret
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
           dmem_req, dmem_we, reg_write, wb_sel, halted, illegal, bus_err, instret
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Fetch/decode/exec/mem/wb sequencer for the multi-cycle RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_HALT   = 3'd5;

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_LD   = 7'b0000011;
  localparam logic [6:0] c_OP_ST   = 7'b0100011;
  localparam logic [6:0] c_OP_BR   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_illegal;
  logic                r_bus_err;
  logic [CNT_W-1:0]    r_instret;
  logic                w_set_illegal;
  logic                w_set_bus_err;
  logic                w_timeout;

  logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal, w_is_jalr, w_supported;

  logic       w_imem_req, w_ir_write, w_pc_write, w_alu_src_a;
  logic       w_dmem_req, w_dmem_we, w_reg_write, w_halted;
  logic [1:0] w_pc_src, w_alu_src_b, w_alu_op, w_wb_sel;

  assign w_is_r      = (bus.opcode == c_OP_R);
  assign w_is_i      = (bus.opcode == c_OP_I);
  assign w_is_ld     = (bus.opcode == c_OP_LD);
  assign w_is_st     = (bus.opcode == c_OP_ST);
  assign w_is_br     = (bus.opcode == c_OP_BR);
  assign w_is_jal    = (bus.opcode == c_OP_JAL);
  assign w_is_jalr   = (bus.opcode == c_OP_JALR);
  assign w_supported = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br | w_is_jal | w_is_jalr;
  assign w_timeout   = (r_wait == c_WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      c_FETCH: begin
        if (bus.imem_ready) begin
          w_next = c_DECODE;
        end else if (w_timeout) begin
          w_next        = c_HALT;
          w_set_bus_err = 1'b1;
        end
      end
      c_DECODE: begin
        if (w_supported) begin
          w_next = c_EXEC;
        end else begin
          w_next        = c_HALT;
          w_set_illegal = 1'b1;
        end
      end
      c_EXEC: begin
        if (w_is_r || w_is_i)        w_next = c_WB;
        else if (w_is_ld || w_is_st) w_next = c_MEM;
        else                         w_next = c_FETCH;
      end
      c_MEM: begin
        if (bus.dmem_ready) begin
          w_next = w_is_ld ? c_WB : c_FETCH;
        end else if (w_timeout) begin
          w_next        = c_HALT;
          w_set_bus_err = 1'b1;
        end
      end
      c_WB:    w_next = c_FETCH;
      c_HALT:  w_next = c_HALT;
      default: w_next = c_FETCH;
    endcase
  end

  // Outputs are forced low while reset is high so an abort drops strobes at once.
  always_comb begin
    w_imem_req  = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 2'b00;
    w_alu_src_a = 1'b0;
    w_alu_src_b = 2'b00;
    w_alu_op    = 2'b00;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_reg_write = 1'b0;
    w_wb_sel    = 2'b00;
    w_halted    = 1'b0;
    if (!reset) begin
      case (r_state)
        c_FETCH: begin
          w_imem_req = 1'b1;
          w_ir_write = bus.imem_ready;
        end
        c_EXEC: begin
          if (w_is_r) begin
            w_alu_op = 2'b10;
          end else if (w_is_i) begin
            w_alu_src_b = 2'b01;
            w_alu_op    = 2'b11;
          end else if (w_is_ld || w_is_st) begin
            w_alu_src_b = 2'b01;
          end else if (w_is_br) begin
            w_alu_op   = 2'b01;
            w_pc_write = 1'b1;
            w_pc_src   = bus.branch_taken ? 2'b01 : 2'b00;
          end else if (w_is_jal) begin
            w_reg_write = 1'b1;
            w_wb_sel    = 2'b10;
            w_pc_write  = 1'b1;
            w_pc_src    = 2'b01;
          end else if (w_is_jalr) begin
            w_alu_src_b = 2'b01;
            w_reg_write = 1'b1;
            w_wb_sel    = 2'b10;
            w_pc_write  = 1'b1;
            w_pc_src    = 2'b10;
          end
        end
        c_MEM: begin
          w_dmem_req = 1'b1;
          w_dmem_we  = w_is_st;
          w_pc_write = bus.dmem_ready & w_is_st;
        end
        c_WB: begin
          w_reg_write = 1'b1;
          w_wb_sel    = w_is_ld ? 2'b01 : 2'b00;
          w_pc_write  = 1'b1;
        end
        c_HALT:  w_halted = 1'b1;
        default: ;
      endcase
    end
  end

  // The wait counter only keeps counting while the FSM lingers in FETCH or MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_instret <= '0;
    end else begin
      if ((w_next == r_state) && ((r_state == c_FETCH) || (r_state == c_MEM))) begin
        r_wait <= r_wait + c_WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_pc_write)    r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign bus.imem_req  = w_imem_req;
  assign bus.ir_write  = w_ir_write;
  assign bus.pc_write  = w_pc_write;
  assign bus.pc_src    = w_pc_src;
  assign bus.alu_src_a = w_alu_src_a;
  assign bus.alu_src_b = w_alu_src_b;
  assign bus.alu_op    = w_alu_op;
  assign bus.dmem_req  = w_dmem_req;
  assign bus.dmem_we   = w_dmem_we;
  assign bus.reg_write = w_reg_write;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.halted    = w_halted;
  assign bus.illegal   = r_illegal;
  assign bus.bus_err   = r_bus_err;
  assign bus.instret   = r_instret;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I datapath. It sequences fetch, decode, execute, memory and write-back for the opcode subset that the immediate generator supports, plus R-type. It drives the datapath muxes and strobes, and handshakes with the instruction and data memories. It also counts retired instructions and halts on illegal opcodes or memory timeouts.

## Interface
Parameters:
- TIMEOUT, 16: consecutive not-ready cycles tolerated on either memory handshake before a bus error; legal range ≥1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  7  IR[6:0]; stable from DECODE until the next FETCH.
- branch_taken  in  1  datapath comparator result; sampled in EXEC for branches only.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 00 = pc+4, 01 = pc+imm, 10 = (alu_result & ~1).
- alu_src_a  out  1  ALU operand A: 0 = rs1, 1 = pc.
- alu_src_b  out  2  ALU operand B: 00 = rs2, 01 = imm.
- alu_op  out  2  00 = add, 01 = compare (branch), 10 = R-funct decode, 11 = I-funct decode.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable.
- reg_write  out  1  register file write.
- wb_sel  out  2  write-back source: 00 = ALU, 01 = memory, 10 = pc+4.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky flag: unsupported opcode.
- bus_err  out  1  sticky flag: memory timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. The state register, wait counter, flags and instret are registered.
- Outputs are combinational from the state, opcode and ready inputs. Any output not listed for a state is 0.
- FETCH
  - imem_req=1.
  - On imem_ready: ir_write=1, go to DECODE.
- DECODE (1 cycle, no strobes)
  - Supported opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 and 1100111. Any of these goes to EXEC.
  - Any other opcode sets illegal and goes to HALT.
- EXEC, by opcode:
  - R-type: src_b=00, alu_op=10, then WB.
  - I-ALU: src_b=01, alu_op=11, then WB.
  - Load/store: src_b=01, alu_op=00, then MEM.
  - Branch: alu_op=01, pc_write=1, pc_src=01 if branch_taken else 00, then FETCH.
  - JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01, then FETCH.
  - JALR: src_b=01, alu_op=00, reg_write=1, wb_sel=10, pc_write=1, pc_src=10, then FETCH.
- MEM
  - dmem_req=1; dmem_we=1 for a store.
  - On dmem_ready, store: pc_write=1, pc_src=00, then FETCH.
  - On dmem_ready, load: go to WB.
- WB
  - reg_write=1, wb_sel=01 for a load else 00.
  - pc_write=1, pc_src=00, then FETCH.
- HALT: all strobes 0, halted=1. The only exit is reset.
- Retirement
  - Retirement is the cycle in which pc_write=1. instret increments by 1 on that edge.
  - instret wraps from 2^CNT_W−1 to 0.
- Wait counter
  - Cleared on entry to FETCH or MEM.
  - Increments every FETCH/MEM cycle with ready low.
  - If ready is low while the counter equals TIMEOUT−1, set bus_err and go to HALT. This is exactly TIMEOUT consecutive low cycles.
  - Ready high in any earlier cycle proceeds normally.
- illegal and bus_err are set only as described above and clear only on reset.

## Timing
- Reset asserted: state=FETCH, instret=0, illegal=0, bus_err=0, wait counter=0, and every output is 0, including imem_req.
- imem_req rises combinationally in the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts immediately; no strobe is asserted while reset is high.
- Zero-wait-state cycle counts (FETCH to next FETCH):
  - R/I-ALU: 4.
  - Load: 5.
  - Store: 4.
  - Branch, JAL, JALR: 3.
- Each memory wait cycle adds 1.
- Ready inputs are ignored outside their own state (imem_ready in FETCH, dmem_ready in MEM).
- A ready pulse in the same cycle the FSM enters the state is honoured.
- Back-to-back instructions: the cycle after the retiring edge is FETCH with imem_req=1.
- The opcode and branch_taken inputs must be stable before the rising edge of any cycle in which they are used.

## Test plan
- Reset, then an R-type (0110011) with ready always high → states FETCH, DECODE, EXEC, WB. reg_write=1 only in WB, wb_sel=00, instret=1 after 4 cycles.
- Load with dmem_ready low for 3 cycles → MEM lasts 4 cycles with dmem_req=1 and dmem_we=0. WB has wb_sel=01, retirement occurs at cycle 8.
- Branch with branch_taken=1, then with branch_taken=0 → pc_src=01, then 00. pc_write=1 in EXEC both times, 3 cycles each.
- Opcode 0110111 → illegal=1 and halted=1 after DECODE, all strobes then 0 for 20 cycles. Reset clears the flags and fetch resumes.
- TIMEOUT=4 with imem_ready held low → bus_err set after 4 FETCH cycles. A repeat with ready high on the 4th cycle proceeds normally.
- CNT_W=4: retire 17 instructions → instret=1 (wrap). Assert reset during MEM of a store → dmem_req drops immediately and instret=0.
